// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan sequencer.
package scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_SHOW,
      S_HOLD
   } state_t;

   localparam int unsigned NUM_DIGITS_MAX = 8;
   localparam logic [7:0]  AN_OFF         = 8'hFF;

   // Active-low one-hot anode pattern for a digit position.
   function automatic logic [7:0] anode_on(input logic [2:0] pos);
      return ~(8'd1 << pos);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; counts toward zero and holds there, flagging zero.
module scan_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scans an 8:1 digit mux through NUM_DIGITS positions with blank/dwell timing,
// auto or single-step, registering the selected digit for the decoder.
module digit_scan_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned DWELL      = 16,
   parameter int unsigned BLANK      = 2,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       manual,
   input  logic [3:0] din,
   output logic [2:0] sel,
   output logic       en_n,
   output logic [7:0] digit_an,
   output logic [3:0] seg_data,
   output logic       frame_done,
   output logic       busy
);

   localparam int unsigned TMAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DWELL_LD = TW'(DWELL - 1);
   localparam logic [TW-1:0] BLANK_LD = TW'(BLANK - 1);
   localparam logic [2:0]    LAST_SEL = 3'(NUM_DIGITS - 1);

   state_t       state, state_n;
   logic [2:0]   sel_n, sel_adv;
   logic         stop_pend, pend_n;
   logic         fd_n;
   logic         t_load, t_zero;
   logic [TW-1:0] t_val;
   logic         lit_n;

   scan_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   assign sel_adv = (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;

   always_comb begin
      state_n = state;
      sel_n   = sel;
      pend_n  = stop_pend;
      fd_n    = 1'b0;
      t_load  = 1'b0;
      t_val   = BLANK_LD;
      unique case (state)
         S_IDLE: begin
            if (start && !stop) begin
               state_n = S_BLANK;
               sel_n   = 3'd0;
               t_load  = 1'b1;
            end
         end
         S_BLANK: begin
            if (stop) pend_n = 1'b1;
            if (t_zero) begin
               state_n = S_SHOW;
               t_load  = 1'b1;
               t_val   = DWELL_LD;
            end
         end
         S_SHOW: begin
            if (t_zero) begin
               if (stop_pend || stop) begin
                  state_n = S_IDLE;
                  pend_n  = 1'b0;
               end else if (manual) begin
                  state_n = S_HOLD;
               end else begin
                  state_n = S_BLANK;
                  sel_n   = sel_adv;
                  t_load  = 1'b1;
                  fd_n    = (sel == LAST_SEL);
               end
            end else if (stop) begin
               pend_n = 1'b1;
            end
         end
         S_HOLD: begin
            if (stop) begin
               state_n = S_IDLE;
               pend_n  = 1'b0;
            end else if (step || !manual) begin
               state_n = S_BLANK;
               sel_n   = sel_adv;
               t_load  = 1'b1;
               fd_n    = (sel == LAST_SEL);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign lit_n = (state_n == S_SHOW) || (state_n == S_HOLD);

   // Mux controls are registered from next-state so they line up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         sel        <= 3'd0;
         en_n       <= 1'b1;
         digit_an   <= AN_OFF;
         seg_data   <= 4'd0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         stop_pend  <= 1'b0;
      end else begin
         state      <= state_n;
         sel        <= sel_n;
         en_n       <= !lit_n;
         digit_an   <= lit_n ? anode_on(sel_n) : AN_OFF;
         frame_done <= fd_n;
         busy       <= (state_n != S_IDLE);
         stop_pend  <= pend_n;
         if (state == S_SHOW || state == S_HOLD) seg_data <= din;
      end
   end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: directed table, hand sequences,
// and randomized auto-mode traffic against a slot-arithmetic reference model.
module tb_digit_scan_ctrl;

   localparam int SLOT  = 18;   // BLANK + DWELL
   localparam int FRAME = 144;  // 8 slots

   logic       clk = 1'b0;
   logic       rst, start, stop, step, manual;
   logic [3:0] din;
   logic [2:0] sel;
   logic       en_n;
   logic [7:0] digit_an;
   logic [3:0] seg_data;
   logic       frame_done, busy;

   logic [3:0] mux_tbl [8];
   int checks = 0;
   int failures = 0;

   digit_scan_ctrl #(.DWELL(16), .BLANK(2), .NUM_DIGITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .manual     (manual),
      .din        (din),
      .sel        (sel),
      .en_n       (en_n),
      .digit_an   (digit_an),
      .seg_data   (seg_data),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the 8:1 mux feeding din.
   always_comb din = en_n ? 4'd0 : mux_tbl[sel];

   typedef struct {
      bit rst, start, stop, step, manual;
      int n;
      bit chk_sel;
      int sel, en_n, busy;
   } vec_t;

   vec_t tv[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int an_exp(input int s, input int off);
      logic [7:0] v;
      v = 8'hFF;
      if (off == 0) v[s] = 1'b0;
      return int'(v);
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 0; stop = 0; step = 0;
      tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      int k, end_k, d, p, n;
      bit active, ok, sp, st;
      logic [3:0] seg_m;

      mux_tbl[0] = 4'hA; mux_tbl[1] = 4'h5; mux_tbl[2] = 4'h4; mux_tbl[3] = 4'h0;
      mux_tbl[4] = 4'h3; mux_tbl[5] = 4'h0; mux_tbl[6] = 4'h9; mux_tbl[7] = 4'h1;
      rst = 1; start = 0; stop = 0; step = 0; manual = 0;

      //            rst st sp stp man n   cs sel en busy
      tv.push_back('{1, 0, 0, 0, 1, 2,  1, 0, 1, 0});  // reset
      tv.push_back('{0, 1, 1, 0, 1, 1,  1, 0, 1, 0});  // start+stop: stays idle
      tv.push_back('{0, 0, 1, 0, 1, 1,  1, 0, 1, 0});  // stop in idle ignored
      tv.push_back('{0, 1, 0, 0, 1, 1,  1, 0, 1, 1});  // blank 0
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 0, 1, 1});  // blank 1
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 0, 0, 1});  // show first
      tv.push_back('{0, 0, 0, 0, 1, 15, 1, 0, 0, 1});  // show last
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 0, 0, 1});  // hold
      tv.push_back('{0, 0, 0, 0, 1, 40, 1, 0, 0, 1});  // hold indefinitely
      tv.push_back('{0, 1, 0, 0, 1, 1,  1, 0, 0, 1});  // start while busy ignored
      tv.push_back('{0, 0, 0, 1, 1, 1,  1, 1, 1, 1});  // step -> blank sel1
      tv.push_back('{0, 0, 0, 1, 1, 1,  1, 1, 1, 1});  // step in blank ignored
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 1, 0, 1});  // show sel1
      tv.push_back('{0, 0, 0, 0, 1, 15, 1, 1, 0, 1});
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 1, 0, 1});  // hold sel1
      tv.push_back('{0, 0, 1, 1, 1, 1,  0, 0, 1, 0});  // step+stop: stop wins
      tv.push_back('{0, 1, 0, 0, 1, 1,  1, 0, 1, 1});  // restart at sel0
      tv.push_back('{0, 0, 0, 0, 1, 17, 1, 0, 0, 1});
      tv.push_back('{0, 0, 0, 0, 1, 1,  1, 0, 0, 1});  // hold
      tv.push_back('{0, 0, 0, 0, 0, 1,  1, 1, 1, 1});  // manual released -> advance
      tv.push_back('{0, 0, 0, 0, 0, 18, 1, 2, 1, 1});  // auto scan into sel2
      tv.push_back('{0, 0, 1, 0, 0, 1,  1, 2, 1, 1});  // stop in blank pends
      tv.push_back('{0, 0, 0, 0, 0, 16, 1, 2, 0, 1});  // dwell completes
      tv.push_back('{0, 0, 0, 0, 0, 1,  0, 0, 1, 0});  // then idle

      foreach (tv[i]) begin
         rst = tv[i].rst; start = tv[i].start; stop = tv[i].stop;
         step = tv[i].step; manual = tv[i].manual;
         tick();
         rst = tv[i].rst; start = 0; stop = 0; step = 0;
         for (int c = 1; c < tv[i].n; c++) tick();
         rst = 0;
         if (tv[i].chk_sel) check($sformatf("tv%0d_sel", i), int'(sel), tv[i].sel);
         check($sformatf("tv%0d_en_n", i), int'(en_n), tv[i].en_n);
         check($sformatf("tv%0d_busy", i), int'(busy), tv[i].busy);
         check($sformatf("tv%0d_fd", i), int'(frame_done), 0);
         if (tv[i].chk_sel)
            check($sformatf("tv%0d_an", i), int'(digit_an), an_exp(tv[i].sel, tv[i].en_n));
         else
            check($sformatf("tv%0d_an", i), int'(digit_an), 8'hFF);
      end

      // Full auto frame: frame_done 144 cycles after blank entry, sel wrapped.
      manual = 0;
      do_reset();
      check("rst_seg", int'(seg_data), 0);
      start = 1; tick(); start = 0;
      n = 0; ok = 0;
      for (int c = 1; c <= 300 && !ok; c++) begin
         tick();
         if (frame_done) begin ok = 1; n = c; end
      end
      check("frame_seen", int'(ok), 1);
      check("frame_latency", n, FRAME);
      check("frame_sel_wrap", int'(sel), 0);
      check("frame_blank", int'(en_n), 1);
      check("frame_seg_last", int'(seg_data), 1);
      tick();
      check("frame_pulse_len", int'(frame_done), 0);

      // Stop at SHOW cycle 5 of sel=3: finishes dwell, idles without frame_done.
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (sel == 3'd3 && en_n == 1'b0) ok = 1; else tick();
      end
      check("wait_sel3", int'(ok), 1);
      tick(); tick(); tick(); tick();
      stop = 1; tick(); stop = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("stop_hold_sel", int'(sel), 3);
         check("stop_hold_busy", int'(busy), 1);
      end
      tick();
      check("stop_busy", int'(busy), 0);
      check("stop_en_n", int'(en_n), 1);
      check("stop_an", int'(digit_an), 8'hFF);
      check("stop_fd", int'(frame_done), 0);

      // Reset mid-SHOW at sel=5.
      start = 1; tick(); start = 0;
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (sel == 3'd5 && en_n == 1'b0) ok = 1; else tick();
      end
      check("wait_sel5", int'(ok), 1);
      tick(); tick();
      rst = 1; tick(); rst = 0;
      check("mid_rst_sel", int'(sel), 0);
      check("mid_rst_en_n", int'(en_n), 1);
      check("mid_rst_an", int'(digit_an), 8'hFF);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_fd", int'(frame_done), 0);
      check("mid_rst_seg", int'(seg_data), 0);
      start = 1; tick(); start = 0;
      check("restart_sel", int'(sel), 0);
      check("restart_busy", int'(busy), 1);

      // Randomized auto-mode traffic against slot arithmetic.
      do_reset();
      active = 0; k = 0; end_k = -1; seg_m = 4'd0;
      for (int c = 0; c < 8000; c++) begin
         st = ($urandom_range(0, 99) < 3);
         sp = ($urandom_range(0, 599) == 0);
         start = st; stop = sp;
         step = ($urandom_range(0, 9) == 0);
         if (active) begin
            if ((k % SLOT) >= 2) seg_m = mux_tbl[(k / SLOT) % 8];
            if (sp && end_k < 0) end_k = (k / SLOT) * SLOT + SLOT - 1;
            k++;
            if (end_k >= 0 && k > end_k) active = 0;
         end else if (st && !sp) begin
            active = 1; k = 0; end_k = -1;
         end
         tick();
         start = 0; stop = 0; step = 0;
         if (active) begin
            d = (k / SLOT) % 8;
            p = k % SLOT;
            check("rnd_sel", int'(sel), d);
            check("rnd_en_n", int'(en_n), (p < 2) ? 1 : 0);
            check("rnd_an", int'(digit_an), an_exp(d, (p < 2) ? 1 : 0));
            check("rnd_busy", int'(busy), 1);
            check("rnd_fd", int'(frame_done), (k > 0 && (k % FRAME) == 0) ? 1 : 0);
         end else begin
            check("rnd_idle_en_n", int'(en_n), 1);
            check("rnd_idle_an", int'(digit_an), 8'hFF);
            check("rnd_idle_busy", int'(busy), 0);
            check("rnd_idle_fd", int'(frame_done), 0);
         end
         check("rnd_seg", int'(seg_data), int'(seg_m));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Sequencer for the 8:1 x 4-bit digit select mux (sel[2:0], active-low enable, 4-bit data out). It steps the mux select through all eight positions for time-multiplexed display. Each digit is shown for a programmable dwell with a blanking gap between digits, in either free-running (auto) or single-step (manual) mode. It sits between the mux output and the display anode and segment drivers, and registers the selected digit for the downstream decoder.

Parameters:
DWELL, 16, SHOW cycles per digit (>=2)
BLANK, 2, blanking cycles before each digit (>=1)
NUM_DIGITS, 8, positions scanned (2..8); sel wraps at NUM_DIGITS-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begin scanning from sel=0
stop  in  1  one-cycle pulse; end scanning at next digit boundary
step  in  1  one-cycle pulse; advance one digit (manual mode only)
manual  in  1  0=auto scan, 1=single-step; sampled at each digit boundary
din  in  4  mux data output (combinational from sel/en_n)
sel  out  3  mux select, registered
en_n  out  1  mux enable, active-low, registered
digit_an  out  8  display anodes, active-low one-hot, bit sel low only in SHOW/HOLD
seg_data  out  4  registered digit value for decoder
frame_done  out  1  one-cycle pulse after last digit's SHOW completes
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset (all outputs, next edge): state=IDLE, sel=0, en_n=1, digit_an=8'hFF, seg_data=0, frame_done=0, busy=0, stop_pend=0, timer=0.
- States: IDLE, BLANK, SHOW, HOLD.
- IDLE: en_n=1, anodes off. start -> BLANK, sel=0, timer=BLANK-1. Both start and stop in the same cycle: stop wins and the block stays in IDLE.
- BLANK: en_n=1, digit_an=FF. Timer counts down. At 0 -> SHOW, timer=DWELL-1.
- SHOW: en_n=0, digit_an[sel]=0. seg_data<=din every SHOW cycle, so it lags sel by one cycle. At timer 0 the digit boundary is reached:
  - stop_pend or stop -> IDLE. stop_pend clears, anodes off.
  - else manual=1 -> HOLD.
  - else -> BLANK with sel advanced.
- HOLD: en_n=0, digit_an[sel]=0, seg_data tracks din.
  - stop -> IDLE immediately.
  - step -> BLANK with sel advanced.
  - manual deasserted -> BLANK with sel advanced.
- Advance: sel = (sel==NUM_DIGITS-1) ? 0 : sel+1.
- frame_done pulses for one cycle on the boundary where sel==NUM_DIGITS-1 is left. It does not pulse on a stop exit.
- stop received in BLANK or SHOW sets stop_pend. stop in IDLE is ignored.
- start while busy is ignored. step outside HOLD is ignored.
- step and stop in the same HOLD cycle: stop wins.
- rst mid-operation: immediate return to the reset values, with no frame_done.
- Timer width: clog2(max(DWELL,BLANK)). No arithmetic overflow is possible, because it loads and counts down only.

Decomposition:
- Shared package scan_pkg:
  - state enum (IDLE, BLANK, SHOW, HOLD)
  - NUM_DIGITS_MAX=8
  - localparam for anode-all-off 8'hFF
- One sub-module, scan_timer: loadable down-counter with load, load_val, and a zero flag. It is instantiated once and reused for both BLANK and DWELL.

Test Plan:
- Reset values: rst=1 for 2 cycles -> sel=0, en_n=1, digit_an=FF, busy=0, frame_done=0.
- Auto full frame (DWELL=16, BLANK=2, din driven by the mux): start -> sel visits 0..7. Each digit gives 2 blank cycles, then 16 cycles with en_n=0 and digit_an=~(1<<sel). frame_done pulses once, 144 cycles after BLANK entry, and sel wraps to 0.
- seg_data capture with mux constants: at sel=2..7, seg_data = 4,0,3,0,9,1 one cycle after SHOW entry. With win1=4'hA at sel=0, seg_data=A.
- Manual mode: manual=1, start -> SHOW sel=0, then HOLD indefinitely. step -> BLANK then SHOW at sel=1. A step pulse during BLANK produces no advance.
- Stop handling: stop at SHOW cycle 5 of sel=3 -> stays at sel=3 until the dwell ends, then IDLE with en_n=1, busy=0 and no frame_done. Simultaneous start+stop in IDLE -> stays IDLE.
- Reset mid-SHOW at sel=5 -> next cycle gives the reset values. A subsequent start begins at sel=0.
